// File: rtl/control_p_if.sv
// Bundle between the accumulator datapath and its sequencing controller.
// The datapath side drives opcode/flags; the controller drives strobes and debug state.
interface control_p_if #(
    parameter int OPCODE_W = 3,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_rdy;
    logic                resume;
    logic                rd;
    logic                wr;
    logic                ld_ir;
    logic                ld_acc;
    logic                ld_pc;
    logic                inc_pc;
    logic                halt;
    logic                data_e;
    logic                sel;
    logic [3:0]          phase;
    logic [CNT_W-1:0]    instr_cnt;

    modport master (
        output opcode, zero, mem_rdy, resume,
        input  rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel, phase, instr_cnt
    );

    modport slave (
        input  opcode, zero, mem_rdy, resume,
        output rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel, phase, instr_cnt
    );
endinterface

// File: rtl/control_p.sv
// Eight-phase instruction sequencer with halt/resume, optional memory wait stretching
// and a retired-instruction counter.
//
// state      | meaning
// INST_ADDR  | drive PC onto address bus
// INST_FETCH | read instruction (may stretch on mem_rdy)
// INST_LOAD  | latch instruction register
// IDLE       | settle, IR still loading
// OP_ADDR    | bump PC, detect HLT
// OP_FETCH   | read operand for ALU ops (may stretch)
// ALU_OP     | execute, SKZ skip, jump load
// STORE      | write back / accumulate (STO may stretch)
// HALTED     | parked until resume
module control_p #(
    parameter int OPCODE_W = 3,
    parameter int WAIT_EN  = 0,
    parameter int CNT_W    = 16
) (
    input logic        clk,
    input logic        rst,
    control_p_if.slave bus
);
    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [OPCODE_W-1:0] opc;
    logic [3:0]          op;
    logic                is_hlt, is_skz, is_sto, is_jmp, is_jz, is_alu;
    logic                wait_on, retire;

    // Zero-extend so the 3-bit build never decodes the 4-bit-only opcodes.
    assign opc    = bus.opcode;
    assign op     = 4'(opc);
    assign is_hlt = (op == 4'd0);
    assign is_skz = (op == 4'd1);
    assign is_sto = (op == 4'd6);
    assign is_jmp = (op == 4'd7);
    assign is_jz  = (op == 4'd10);
    assign is_alu = op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9};

    assign wait_on = (WAIT_EN != 0) && !bus.mem_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INST_ADDR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        retire     = 1'b0;
        bus.rd     = 1'b0;
        bus.wr     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.ld_acc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.halt   = 1'b0;
        bus.data_e = 1'b0;
        bus.sel    = 1'b0;
        case (state)
            INST_ADDR: begin
                bus.sel   = 1'b1;
                state_nxt = INST_FETCH;
            end
            INST_FETCH: begin
                bus.sel = 1'b1;
                bus.rd  = 1'b1;
                if (!wait_on) state_nxt = INST_LOAD;
            end
            INST_LOAD: begin
                bus.sel   = 1'b1;
                bus.rd    = 1'b1;
                bus.ld_ir = 1'b1;
                state_nxt = IDLE;
            end
            IDLE: begin
                bus.sel   = 1'b1;
                bus.rd    = 1'b1;
                bus.ld_ir = 1'b1;
                state_nxt = OP_ADDR;
            end
            OP_ADDR: begin
                bus.inc_pc = 1'b1;
                bus.halt   = is_hlt;
                state_nxt  = is_hlt ? HALTED : OP_FETCH;
            end
            OP_FETCH: begin
                bus.rd = is_alu;
                if (!(wait_on && is_alu)) state_nxt = ALU_OP;
            end
            ALU_OP: begin
                bus.rd     = is_alu;
                bus.inc_pc = is_skz && bus.zero;
                bus.ld_pc  = is_jmp || (is_jz && bus.zero);
                bus.data_e = is_sto;
                state_nxt  = STORE;
            end
            STORE: begin
                bus.rd     = is_alu;
                bus.ld_pc  = is_jmp || (is_jz && bus.zero);
                bus.ld_acc = is_alu;
                bus.data_e = is_sto;
                bus.wr     = is_sto;
                if (!(wait_on && is_sto)) begin
                    state_nxt = INST_ADDR;
                    retire    = 1'b1;
                end
            end
            HALTED: begin
                bus.halt = 1'b1;
                if (bus.resume) state_nxt = INST_ADDR;
            end
            default: state_nxt = INST_ADDR;
        endcase
    end

    assign bus.phase     = state;
    assign bus.instr_cnt = cnt;
endmodule
